// File: rtl/signmag_calc_seq.sv
// rtl/signmag_calc_seq.sv - sequential sign-magnitude add/sub/mul calculator
// Optional restoring divider on opcode 3 when SIGNMAG_CALC_DIV_EN is defined.
module signmag_calc_seq #(
  parameter int WIDTH = 4
) (
  input  logic               i_Clk,
  input  logic               i_Reset,
  input  logic               i_Start,
  input  logic [WIDTH:0]     i_A,
  input  logic [WIDTH:0]     i_B,
  input  logic [1:0]         i_Calc,
  output logic               o_Busy,
  output logic               o_Done,
  output logic [2*WIDTH-1:0] o_Result,
  output logic               o_Neg,
  output logic               o_Err
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

  state_t             r_state;
  logic               r_busy;
  logic               r_done;
  logic               r_neg;
  logic               r_err;
  logic [2*WIDTH-1:0] r_result;
  logic [WIDTH-1:0]   r_a_mag;
  logic [WIDTH-1:0]   r_b_mag;
  logic               r_a_neg;
  logic               r_b_neg;
  logic [1:0]         r_op;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_mul_acc;
  logic [2*WIDTH-1:0] r_mul_cand;
  logic [WIDTH-1:0]   r_mul_plier;
`ifdef SIGNMAG_CALC_DIV_EN
  logic [WIDTH-1:0]   r_div_rem;
  logic [WIDTH-1:0]   r_div_quo;
  logic [WIDTH:0]     w_div_shift;
  logic               w_div_ge;
  logic [WIDTH-1:0]   w_div_rem_nx;
  logic [WIDTH-1:0]   w_div_quo_nx;
`endif

  logic               w_a_neg;
  logic               w_b_neg;
  logic               w_last;
  logic [WIDTH+1:0]   w_as_a;
  logic [WIDTH+1:0]   w_as_b;
  logic [WIDTH+1:0]   w_as_sum;
  logic [WIDTH+1:0]   w_as_mag;
  logic [2*WIDTH-1:0] w_mul_sum;
  logic               w_fin;
  logic               w_fin_neg;
  logic               w_fin_err;
  logic [2*WIDTH-1:0] w_fin_res;

  // A zero magnitude is treated as +0 whatever its sign bit says.
  assign w_a_neg = ~i_A[WIDTH] & (|i_A[WIDTH-1:0]);
  assign w_b_neg = ~i_B[WIDTH] & (|i_B[WIDTH-1:0]);
  assign w_last  = (r_cnt == CW'(WIDTH - 1));

  assign w_as_a    = r_a_neg ? -{2'b00, r_a_mag} : {2'b00, r_a_mag};
  assign w_as_b    = r_b_neg ? -{2'b00, r_b_mag} : {2'b00, r_b_mag};
  assign w_as_sum  = r_op[0] ? (w_as_a - w_as_b) : (w_as_a + w_as_b);
  assign w_as_mag  = w_as_sum[WIDTH+1] ? -w_as_sum : w_as_sum;
  assign w_mul_sum = r_mul_acc + (r_mul_plier[0] ? r_mul_cand : '0);

`ifdef SIGNMAG_CALC_DIV_EN
  assign w_div_shift  = {r_div_rem, r_div_quo[WIDTH-1]};
  assign w_div_ge     = (w_div_shift >= {1'b0, r_b_mag});
  assign w_div_rem_nx = w_div_ge ? WIDTH'(w_div_shift - {1'b0, r_b_mag}) : w_div_shift[WIDTH-1:0];
  assign w_div_quo_nx = {r_div_quo[WIDTH-2:0], w_div_ge};
`endif

  // Completion condition and the values latched on the edge entering DONE.
  always_comb begin
    w_fin     = 1'b0;
    w_fin_res = '0;
    w_fin_neg = 1'b0;
    w_fin_err = 1'b0;
    case (r_op)
      2'd0, 2'd1: begin
        w_fin                = 1'b1;
        w_fin_res[WIDTH+1:0] = w_as_mag;
        w_fin_neg            = w_as_sum[WIDTH+1];
      end
      2'd2: begin
        w_fin     = w_last;
        w_fin_res = w_mul_sum;
        w_fin_neg = (r_a_neg ^ r_b_neg) & (|w_mul_sum);
      end
      default: begin
`ifdef SIGNMAG_CALC_DIV_EN
        if (r_b_mag == '0) begin
          w_fin     = 1'b1;
          w_fin_res = '1;
          w_fin_err = 1'b1;
        end else begin
          w_fin     = w_last;
          w_fin_res = {w_div_rem_nx, w_div_quo_nx};
          w_fin_neg = (r_a_neg ^ r_b_neg) & (|w_div_quo_nx);
        end
`else
        w_fin     = 1'b1;
        w_fin_res = '1;
        w_fin_err = 1'b1;
`endif
      end
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      r_state     <= IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_neg       <= 1'b0;
      r_err       <= 1'b0;
      r_result    <= '0;
      r_a_mag     <= '0;
      r_b_mag     <= '0;
      r_a_neg     <= 1'b0;
      r_b_neg     <= 1'b0;
      r_op        <= 2'd0;
      r_cnt       <= '0;
      r_mul_acc   <= '0;
      r_mul_cand  <= '0;
      r_mul_plier <= '0;
`ifdef SIGNMAG_CALC_DIV_EN
      r_div_rem   <= '0;
      r_div_quo   <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_Start) begin
            r_state     <= CALC;
            r_busy      <= 1'b1;
            r_a_mag     <= i_A[WIDTH-1:0];
            r_b_mag     <= i_B[WIDTH-1:0];
            r_a_neg     <= w_a_neg;
            r_b_neg     <= w_b_neg;
            r_op        <= i_Calc;
            r_cnt       <= '0;
            r_mul_acc   <= '0;
            r_mul_cand  <= {{WIDTH{1'b0}}, i_A[WIDTH-1:0]};
            r_mul_plier <= i_B[WIDTH-1:0];
`ifdef SIGNMAG_CALC_DIV_EN
            r_div_rem   <= '0;
            r_div_quo   <= i_A[WIDTH-1:0];
`endif
          end
        end
        CALC: begin
          r_cnt       <= r_cnt + 1'b1;
          r_mul_acc   <= w_mul_sum;
          r_mul_cand  <= r_mul_cand << 1;
          r_mul_plier <= r_mul_plier >> 1;
`ifdef SIGNMAG_CALC_DIV_EN
          r_div_rem   <= w_div_rem_nx;
          r_div_quo   <= w_div_quo_nx;
`endif
          if (w_fin) begin
            r_state  <= DONE;
            r_done   <= 1'b1;
            r_result <= w_fin_res;
            r_neg    <= w_fin_neg;
            r_err    <= w_fin_err;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_Busy   = r_busy;
  assign o_Done   = r_done;
  assign o_Result = r_result;
  assign o_Neg    = r_neg;
  assign o_Err    = r_err;

endmodule

// File: tb/tb_signmag_calc_seq.sv
// tb/tb_signmag_calc_seq.sv - randomized self-checking bench for signmag_calc_seq
// Opcode 3 expectations follow SIGNMAG_CALC_DIV_EN.
module tb_signmag_calc_seq;
  logic       clk = 1'b0;
  logic       i_Reset;
  logic       i_Start;
  logic [4:0] i_A;
  logic [4:0] i_B;
  logic [1:0] i_Calc;
  logic       o_Busy;
  logic       o_Done;
  logic [7:0] o_Result;
  logic       o_Neg;
  logic       o_Err;

  int n_checks = 0;
  int n_errors = 0;

  signmag_calc_seq #(.WIDTH(4)) dut (
    .i_Clk(clk), .i_Reset(i_Reset), .i_Start(i_Start), .i_A(i_A), .i_B(i_B),
    .i_Calc(i_Calc), .o_Busy(o_Busy), .o_Done(o_Done), .o_Result(o_Result),
    .o_Neg(o_Neg), .o_Err(o_Err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on signed values and magnitudes.
  task automatic model(input logic [4:0] a, input logic [4:0] b, input logic [1:0] op,
                       output logic [7:0] res, output logic neg, output logic err,
                       output int lat);
    int am, bm, sa, sb, s;
    bit an, bn;
    am = int'(a[3:0]);
    bm = int'(b[3:0]);
    an = (a[4] == 1'b0) && (am != 0);
    bn = (b[4] == 1'b0) && (bm != 0);
    sa = an ? -am : am;
    sb = bn ? -bm : bm;
    res = 8'h00; neg = 1'b0; err = 1'b0; lat = 1;
    case (op)
      2'd0, 2'd1: begin
        s   = (op == 2'd0) ? sa + sb : sa - sb;
        neg = (s < 0);
        res = 8'((s < 0) ? -s : s);
      end
      2'd2: begin
        s   = am * bm;
        res = 8'(s);
        neg = (an != bn) && (s != 0);
        lat = 4;
      end
      default: begin
`ifdef SIGNMAG_CALC_DIV_EN
        if (bm == 0) begin
          res = 8'hFF; err = 1'b1;
        end else begin
          res = 8'(((am % bm) * 16) + (am / bm));
          neg = (an != bn) && ((am / bm) != 0);
          lat = 4;
        end
`else
        res = 8'hFF; err = 1'b1;
`endif
      end
    endcase
  endtask

  task automatic run_op(input string tag, input logic [4:0] a, input logic [4:0] b,
                        input logic [1:0] op);
    logic [7:0] er;
    logic en, ee;
    int lat;
    bit seen;
    model(a, b, op, er, en, ee, lat);
    @(negedge clk);
    i_A = a; i_B = b; i_Calc = op; i_Start = 1'b1;
    @(posedge clk); #1;
    i_Start = 1'b0;
    i_A = 5'($urandom); i_B = 5'($urandom); i_Calc = 2'($urandom);
    seen = 1'b0;
    for (int n = 1; n <= 20 && !seen; n++) begin
      i_Start = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      if (o_Done) begin
        seen = 1'b1;
        check({tag, "_lat"}, 32'(n), 32'(lat));
        check({tag, "_res"}, 32'(o_Result), 32'(er));
        check({tag, "_neg"}, 32'(o_Neg), 32'(en));
        check({tag, "_err"}, 32'(o_Err), 32'(ee));
      end
      check({tag, "_busy"}, 32'(o_Busy), 32'd1);
    end
    i_Start = 1'b0;
    if (!seen) check({tag, "_timeout"}, 32'd0, 32'd1);
    @(posedge clk); #1;
    check({tag, "_pulse"}, 32'(o_Done), 32'd0);
    check({tag, "_idle"}, 32'(o_Busy), 32'd0);
    check({tag, "_hold"}, 32'(o_Result), 32'(er));
  endtask

  initial begin
    i_Reset = 1'b1; i_Start = 1'b1; i_A = 5'h15; i_B = 5'h03; i_Calc = 2'd2;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(o_Busy), 32'd0);
    check("rst_done", 32'(o_Done), 32'd0);
    check("rst_res", 32'(o_Result), 32'd0);
    check("rst_neg", 32'(o_Neg), 32'd0);
    check("rst_err", 32'(o_Err), 32'd0);
    @(negedge clk);
    i_Reset = 1'b0; i_Start = 1'b0;

    run_op("add", 5'b1_0101, 5'b0_0011, 2'd0);
    run_op("mul", 5'b1_0101, 5'b0_0011, 2'd2);
    run_op("subz", 5'b0_0000, 5'b1_0000, 2'd1);
    run_op("div", 5'b1_1101, 5'b0_0100, 2'd3);
    run_op("div0", 5'b1_1101, 5'b1_0000, 2'd3);
    run_op("mulmax", 5'b0_1111, 5'b0_1111, 2'd2);
    run_op("submax", 5'b0_1111, 5'b1_1111, 2'd1);

    // Abort a multiply with reset at edge k+2.
    @(negedge clk);
    i_A = 5'b1_0101; i_B = 5'b0_0011; i_Calc = 2'd2; i_Start = 1'b1;
    @(posedge clk); #1;
    i_Start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    i_Reset = 1'b1;
    @(posedge clk); #1;
    check("abort_done", 32'(o_Done), 32'd0);
    check("abort_busy", 32'(o_Busy), 32'd0);
    check("abort_res", 32'(o_Result), 32'd0);
    check("abort_neg", 32'(o_Neg), 32'd0);
    check("abort_err", 32'(o_Err), 32'd0);
    @(negedge clk);
    i_Reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("abort_quiet", 32'(o_Done), 32'd0);
    end
    run_op("post_abort", 5'b1_0101, 5'b0_0011, 2'd2);

    for (int i = 0; i < 150; i++)
      run_op("rnd", 5'($urandom), 5'($urandom), 2'($urandom));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
